sram_arbiter: RTL and testbench

//  Two-requester arbiter/sequencer for the 64Kx8 single-port synchronous SRAM.

---
 rtl/sram_arbiter.sv | 163 ++++++++++++++++
 tb/tb_sram_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Two-port arbiter/sequencer for a 64Kx8 single-port synchronous SRAM.
// Define SRAM_ARB_FIXED_PRIO_EN for fixed port-0 priority; default is round-robin.
module sram_arbiter #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req0,
  input  logic              i_req1,
  input  logic              i_we0,
  input  logic              i_we1,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata0,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic              o_gnt0,
  output logic              o_gnt1,
  output logic              o_rvalid0,
  output logic              o_rvalid1,
  output logic [DATA_W-1:0] o_rdata0,
  output logic [DATA_W-1:0] o_rdata1,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_sram_address,
  output logic [DATA_W-1:0] o_sram_data_in,
  output logic              o_sram_we,
  output logic              o_sram_re,
  input  logic [DATA_W-1:0] i_sram_data_out
);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StCapture
  } state_e;

  state_e              r_state, w_state;
  logic                r_port, w_port;
  logic                r_gnt0, w_gnt0;
  logic                r_gnt1, w_gnt1;
  logic                r_rvalid0, w_rvalid0;
  logic                r_rvalid1, w_rvalid1;
  logic [DATA_W-1:0]   r_rdata0, w_rdata0;
  logic [DATA_W-1:0]   r_rdata1, w_rdata1;
  logic                r_busy, w_busy;
  logic [ADDR_W-1:0]   r_addr, w_addr;
  logic [DATA_W-1:0]   r_din, w_din;
  logic                r_we, w_we;
  logic                r_re, w_re;
  logic                w_pick1;
  logic                w_wr;

`ifdef SRAM_ARB_FIXED_PRIO_EN
  assign w_pick1 = i_req1 & ~i_req0;
`else
  logic r_last_gnt;

  // On a tie the port that was not granted last time wins.
  assign w_pick1 = i_req1 & (~i_req0 | ~r_last_gnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_gnt <= 1'b1;
    end else if (w_gnt0 | w_gnt1) begin
      r_last_gnt <= w_pick1;
    end
  end
`endif

  always_comb begin
    w_state   = r_state;
    w_port    = r_port;
    w_gnt0    = 1'b0;
    w_gnt1    = 1'b0;
    w_rvalid0 = 1'b0;
    w_rvalid1 = 1'b0;
    w_rdata0  = r_rdata0;
    w_rdata1  = r_rdata1;
    w_addr    = r_addr;
    w_din     = r_din;
    w_we      = 1'b0;
    w_re      = 1'b0;
    w_wr      = 1'b0;
    case (r_state)
      StIdle: begin
        if (i_req0 | i_req1) begin
          w_port  = w_pick1;
          w_addr  = w_pick1 ? i_addr1 : i_addr0;
          w_din   = w_pick1 ? i_wdata1 : i_wdata0;
          w_wr    = w_pick1 ? i_we1 : i_we0;
          w_we    = w_wr;
          w_re    = ~w_wr;
          w_gnt0  = ~w_pick1;
          w_gnt1  = w_pick1;
          w_state = StIssue;
        end
      end
      StIssue: begin
        w_state = r_we ? StIdle : StCapture;
      end
      StCapture: begin
        // SRAM output is only driven in this cycle, so capture it now.
        if (r_port) begin
          w_rdata1  = i_sram_data_out;
          w_rvalid1 = 1'b1;
        end else begin
          w_rdata0  = i_sram_data_out;
          w_rvalid0 = 1'b1;
        end
        w_state = StIdle;
      end
      default: begin
        w_state = StIdle;
      end
    endcase
    w_busy = (w_state != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_port    <= 1'b0;
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
      r_busy    <= 1'b0;
      r_addr    <= '0;
      r_din     <= '0;
      r_we      <= 1'b0;
      r_re      <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_port    <= w_port;
      r_gnt0    <= w_gnt0;
      r_gnt1    <= w_gnt1;
      r_rvalid0 <= w_rvalid0;
      r_rvalid1 <= w_rvalid1;
      r_rdata0  <= w_rdata0;
      r_rdata1  <= w_rdata1;
      r_busy    <= w_busy;
      r_addr    <= w_addr;
      r_din     <= w_din;
      r_we      <= w_we;
      r_re      <= w_re;
    end
  end

  assign o_gnt0         = r_gnt0;
  assign o_gnt1         = r_gnt1;
  assign o_rvalid0      = r_rvalid0;
  assign o_rvalid1      = r_rvalid1;
  assign o_rdata0       = r_rdata0;
  assign o_rdata1       = r_rdata1;
  assign o_busy         = r_busy;
  assign o_sram_address = r_addr;
  assign o_sram_data_in = r_din;
  assign o_sram_we      = r_we;
  assign o_sram_re      = r_re;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural SRAM and a read-data scoreboard.
// Define SRAM_ARB_FIXED_PRIO_EN to also exercise the fixed-priority build.
module tb_sram_arbiter;

  logic        clk;
  logic        rst;
  logic        req    [2];
  logic        we     [2];
  logic [15:0] addr   [2];
  logic [7:0]  wdata  [2];
  logic        gnt    [2];
  logic        rvalid [2];
  logic [7:0]  rdata  [2];
  logic        busy;
  logic [15:0] sram_addr;
  logic [7:0]  sram_din;
  logic        sram_we;
  logic        sram_re;
  logic [7:0]  sram_dout;

  sram_arbiter #(
    .ADDR_W(16),
    .DATA_W(8)
  ) u_dut (
    .clk             (clk),
    .rst             (rst),
    .i_req0          (req[0]),
    .i_req1          (req[1]),
    .i_we0           (we[0]),
    .i_we1           (we[1]),
    .i_addr0         (addr[0]),
    .i_addr1         (addr[1]),
    .i_wdata0        (wdata[0]),
    .i_wdata1        (wdata[1]),
    .o_gnt0          (gnt[0]),
    .o_gnt1          (gnt[1]),
    .o_rvalid0       (rvalid[0]),
    .o_rvalid1       (rvalid[1]),
    .o_rdata0        (rdata[0]),
    .o_rdata1        (rdata[1]),
    .o_busy          (busy),
    .o_sram_address  (sram_addr),
    .o_sram_data_in  (sram_din),
    .o_sram_we       (sram_we),
    .o_sram_re       (sram_re),
    .i_sram_data_out (sram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read SRAM that floats its output when not reading.
  logic [7:0] sram_mem [0:65535];
  logic [7:0] sram_rd_q;
  logic       sram_rd_en_q;
  int         cyc, we_cnt, re_cnt, overlap_cnt;

  initial begin
    sram_rd_en_q = 1'b0;
    sram_rd_q    = 8'h00;
    cyc          = 0;
    we_cnt       = 0;
    re_cnt       = 0;
    overlap_cnt  = 0;
  end

  always @(posedge clk) begin
    if (sram_we) sram_mem[sram_addr] <= sram_din;
    if (sram_re) sram_rd_q <= sram_mem[sram_addr];
    sram_rd_en_q <= sram_re;
    cyc          <= cyc + 1;
    if (sram_we) we_cnt <= we_cnt + 1;
    if (sram_re) re_cnt <= re_cnt + 1;
    if (sram_we && sram_re) overlap_cnt <= overlap_cnt + 1;
  end

  assign sram_dout = sram_rd_en_q ? sram_rd_q : 8'hzz;

  typedef struct {
    int         port;
    logic [7:0] data;
  } exp_t;

  exp_t       sb [$];
  logic [7:0] ref_mem [int];
  int         n_checks;
  int         n_errors;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_gnt(output int p, output int lat);
    p   = -1;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (gnt[0] || gnt[1]) begin
        p   = gnt[1] ? (gnt[0] ? 2 : 1) : 0;
        lat = i;
        break;
      end
    end
  endtask

  task automatic check_read(input string tag, output int lat);
    int   p;
    exp_t e;
    logic [7:0] obs;
    p   = -1;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (rvalid[0] || rvalid[1]) begin
        p   = rvalid[1] ? (rvalid[0] ? 2 : 1) : 0;
        lat = i;
        break;
      end
    end
    e.port = -2;
    e.data = 8'h00;
    if (sb.size() > 0) e = sb.pop_front();
    obs = (p == 0) ? rdata[0] : (p == 1) ? rdata[1] : 8'hxx;
    chk({tag, "_rv_port"}, 64'(p), 64'(e.port));
    chk({tag, "_rdata"}, 64'(obs), 64'(e.data));
  endtask

  task automatic access(input int p, input bit w, input logic [15:0] a, input logic [7:0] d,
                        input string tag);
    int gp, gl, rl;
    req[p]   = 1'b1;
    we[p]    = w;
    addr[p]  = a;
    wdata[p] = d;
    wait_gnt(gp, gl);
    chk({tag, "_gnt"}, 64'(gp), 64'(p));
    chk({tag, "_gnt_lat"}, 64'(gl), 64'd1);
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    req[p] = 1'b0;
    if (w) begin
      ref_mem[int'(a)] = d;
      @(negedge clk);
    end else begin
      sb.push_back('{p, ref_mem[int'(a)]});
      check_read(tag, rl);
      chk({tag, "_rd_lat"}, 64'(gl + rl), 64'd3);
    end
  endtask

  task automatic check_outs_zero(input string tag);
    chk(tag, 64'({gnt[0], gnt[1], rvalid[0], rvalid[1], rdata[0], rdata[1], busy,
                  sram_addr, sram_din, sram_we, sram_re}), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int gp, gl, rl, last_cyc, we0, re0;
    logic [7:0] other;
    logic seen;
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req[i]   = 1'b0;
      we[i]    = 1'b0;
      addr[i]  = 16'h0000;
      wdata[i] = 8'h00;
    end
    @(negedge clk);
    @(negedge clk);
    check_outs_zero("reset_outs");
    rst = 1'b0;

    // Single-port write then read.
    access(0, 1'b1, 16'h1234, 8'hA5, "t1_wr");
    access(0, 1'b0, 16'h1234, 8'h00, "t1_rd");

    // Round-robin from reset with both ports reading.
    access(0, 1'b1, 16'h0010, 8'h11, "t2_wr0");
    access(1, 1'b1, 16'h0020, 8'h22, "t2_wr1");
    do_reset();
    req[0]  = 1'b1; we[0] = 1'b0; addr[0] = 16'h0010;
    req[1]  = 1'b1; we[1] = 1'b0; addr[1] = 16'h0020;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(gp, gl);
      chk($sformatf("t2_rr_gnt%0d", k), 64'(gp), 64'(k % 2));
      if (gp == 0 || gp == 1) begin
        sb.push_back('{gp, ref_mem[int'(addr[gp])]});
        if (k >= 3) req[gp] = 1'b0;
        other = rdata[1 - gp];
        check_read($sformatf("t2_rd%0d", k), rl);
        chk($sformatf("t2_other_hold%0d", k), 64'(rdata[1 - gp]), 64'(other));
      end
    end
    req[0] = 1'b0;
    req[1] = 1'b0;
    @(negedge clk);

    // Back-to-back writes on port 1 with request held.
    we0 = we_cnt;
    re0 = re_cnt;
    last_cyc = 0;
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 16'h0000; wdata[1] = 8'h30;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(gp, gl);
      chk($sformatf("t3_gnt%0d", k), 64'(gp), 64'd1);
      if (k > 0) chk($sformatf("t3_gap%0d", k), 64'(cyc - last_cyc), 64'd2);
      last_cyc = cyc;
      ref_mem[k] = 8'h30 + 8'(k);
      @(posedge clk);
      #1;
      if (k < 3) begin
        addr[1]  = 16'(k + 1);
        wdata[1] = 8'h30 + 8'(k + 1);
      end else begin
        req[1] = 1'b0;
      end
    end
    repeat (3) @(negedge clk);
    chk("t3_we_pulses", 64'(we_cnt - we0), 64'd4);
    chk("t3_re_pulses", 64'(re_cnt - re0), 64'd0);
    access(1, 1'b0, 16'h0003, 8'h00, "t3_rdback");

    // Address wrap: top and bottom addresses stay distinct.
    access(0, 1'b1, 16'hFFFF, 8'h5A, "t4_wr_top");
    access(1, 1'b1, 16'h0000, 8'hC3, "t4_wr_bot");
    access(0, 1'b0, 16'hFFFF, 8'h00, "t4_rd_top");
    access(1, 1'b0, 16'h0000, 8'h00, "t4_rd_bot");

    // Reset during CAPTURE of a port-0 read.
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 16'h1234;
    wait_gnt(gp, gl);
    chk("t5_gnt", 64'(gp), 64'd0);
    req[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_outs_zero("t5_async_clear");
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rvalid[0] || rvalid[1]) seen = 1'b1;
    end
    chk("t5_no_rvalid", 64'(seen), 64'd0);
    check_outs_zero("t5_outs_idle");
    access(1, 1'b0, 16'h0020, 8'h00, "t5_rd1");

`ifdef SRAM_ARB_FIXED_PRIO_EN
    // Fixed priority: port 0 starves port 1 until it drops its request.
    do_reset();
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 16'h0010;
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 16'h0020;
    for (int k = 0; k < 6; k++) begin
      wait_gnt(gp, gl);
      chk($sformatf("t6_gnt%0d", k), 64'(gp), 64'd0);
      sb.push_back('{0, ref_mem[16'h0010]});
      if (k == 5) req[0] = 1'b0;
      check_read($sformatf("t6_rd%0d", k), rl);
    end
    wait_gnt(gp, gl);
    chk("t6_gnt1", 64'(gp), 64'd1);
    chk("t6_gnt1_lat", 64'(gl), 64'd1);
    sb.push_back('{1, ref_mem[16'h0020]});
    req[1] = 1'b0;
    check_read("t6_rd1", rl);
`endif

    chk("we_re_overlap", 64'(overlap_cnt), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
